// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI flash XIP read sequencer: SPI register map,
// CTRL bit layout, flash opcode and sequencer state encoding.
package spi_xip_pkg;

    localparam logic [4:0] ADR_RX0     = 5'h00;
    localparam logic [4:0] ADR_TX1     = 5'h04;
    localparam logic [4:0] ADR_CTRL    = 5'h10;
    localparam logic [4:0] ADR_DIVIDER = 5'h14;
    localparam logic [4:0] ADR_SS      = 5'h18;

    localparam int unsigned CTRL_GO_BSY   = 8;
    localparam logic [6:0]  CTRL_CHAR_LEN = 7'd64;
    localparam logic [31:0] CTRL_GO_WORD  = (32'd1 << CTRL_GO_BSY) | {25'd0, CTRL_CHAR_LEN};

    localparam logic [7:0] FLASH_READ_OP = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_TX1,
        ST_WR_DIV,
        ST_WR_SS,
        ST_WR_CTRL,
        ST_POLL,
        ST_CLR_SS,
        ST_RD_RX0,
        ST_RESP
    } xip_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_wb_access.sv
// Single-access Wishbone master: a start pulse launches one registered cycle,
// held stable until ack/err; done/err/rdata are registered one-cycle results.
module spi_wb_access (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  adr,
    input  logic [31:0] dat,
    input  logic        we,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [4:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        // err has priority over ack; the terminating edge drops the cycle
        if (cyc_q && (wb_ack_i || wb_err_i)) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            adr_d   = '0;
            dat_d   = '0;
            sel_d   = '0;
            done_d  = 1'b1;
            err_d   = wb_err_i;
            rdata_d = wb_err_i ? '0 : wb_dat_i;
        end else if (start && !cyc_q) begin
            cyc_d = 1'b1;
            we_d  = we;
            adr_d = adr;
            dat_d = dat;
            sel_d = we ? 4'hF : 4'h0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule

// File: rtl/spi_xip_seq.sv
// Flash XIP read sequencer driving the SPI master's WB register port.
// Define SPI_XIP_BSWAP_EN to return RX0 byte-reversed (first flash byte in [7:0]).
module spi_xip_seq
    import spi_xip_pkg::*;
#(
    parameter logic [15:0] CLK_DIV  = 16'h0001,
    parameter logic [7:0]  SS_MASK  = 8'h01,
    parameter int unsigned POLL_MAX = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned CW = $clog2(POLL_MAX + 1);

    xip_state_t  state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        errf_q, errf_d;
    logic [31:0] data_q, data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic        req_ready_q, busy_q;

    logic        acc_start, acc_we, acc_done, acc_err;
    logic [4:0]  acc_adr;
    logic [31:0] acc_dat, acc_rdata, rx_fmt;

`ifdef SPI_XIP_BSWAP_EN
    assign rx_fmt = bswap32(acc_rdata);
`else
    assign rx_fmt = acc_rdata;
`endif

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        errf_d       = errf_q;
        data_d       = data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_WR_TX1;
                    addr_d     = req_addr;
                    cnt_d      = '0;
                    errf_d     = 1'b0;
                    data_d     = '0;
                    resp_err_d = 1'b0;
                end
            end
            ST_WR_TX1, ST_WR_DIV, ST_WR_SS, ST_WR_CTRL: begin
                if (acc_done) begin
                    if (acc_err) begin
                        state_d = ST_CLR_SS;
                        errf_d  = 1'b1;
                    end else begin
                        case (state_q)
                            ST_WR_TX1: state_d = ST_WR_DIV;
                            ST_WR_DIV: state_d = ST_WR_SS;
                            ST_WR_SS:  state_d = ST_WR_CTRL;
                            default:   state_d = ST_POLL;
                        endcase
                    end
                end
            end
            ST_POLL: begin
                if (acc_done) begin
                    if (acc_err) begin
                        state_d = ST_CLR_SS;
                        errf_d  = 1'b1;
                    end else if (acc_rdata[CTRL_GO_BSY]) begin
                        if (cnt_inc == CW'(POLL_MAX)) begin
                            state_d = ST_CLR_SS;
                            errf_d  = 1'b1;
                        end else begin
                            cnt_d   = cnt_inc;
                            state_d = ST_POLL;
                        end
                    end else begin
                        state_d = ST_CLR_SS;
                    end
                end
            end
            ST_CLR_SS: begin
                if (acc_done) begin
                    if (errf_q || acc_err) begin
                        errf_d       = 1'b1;
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_RD_RX0;
                    end
                end
            end
            ST_RD_RX0: begin
                if (acc_done) begin
                    if (acc_err) begin
                        state_d = ST_CLR_SS;
                        errf_d  = 1'b1;
                    end else begin
                        data_d       = rx_fmt;
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A new access launches on the same edge that enters (or re-enters) its state.
    always_comb begin
        acc_start = ((state_q == ST_IDLE) && req_valid) || (acc_done && (state_d != ST_RESP));
        acc_adr   = '0;
        acc_dat   = '0;
        acc_we    = 1'b0;
        case (state_d)
            ST_WR_TX1:  begin acc_adr = ADR_TX1;     acc_dat = {FLASH_READ_OP, addr_d}; acc_we = 1'b1; end
            ST_WR_DIV:  begin acc_adr = ADR_DIVIDER; acc_dat = {16'h0000, CLK_DIV};     acc_we = 1'b1; end
            ST_WR_SS:   begin acc_adr = ADR_SS;      acc_dat = {24'h000000, SS_MASK};   acc_we = 1'b1; end
            ST_WR_CTRL: begin acc_adr = ADR_CTRL;    acc_dat = CTRL_GO_WORD;            acc_we = 1'b1; end
            ST_POLL:    begin acc_adr = ADR_CTRL; end
            ST_CLR_SS:  begin acc_adr = ADR_SS;      acc_we = 1'b1; end
            ST_RD_RX0:  begin acc_adr = ADR_RX0; end
            default:    begin acc_adr = '0; end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            errf_q       <= 1'b0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            errf_q       <= errf_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            req_ready_q  <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    spi_wb_access u_access (
        .clock    (clock),
        .reset    (reset),
        .start    (acc_start),
        .adr      (acc_adr),
        .dat      (acc_dat),
        .we       (acc_we),
        .done     (acc_done),
        .err      (acc_err),
        .rdata    (acc_rdata),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_xip_seq.sv
// Directed bench for spi_xip_seq: default instance plus a POLL_MAX=4 instance
// for the poll-timeout case; small WB slave models answer each instance.
module tb_spi_xip_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

`ifdef SPI_XIP_BSWAP_EN
    localparam logic [31:0] EXP_11223344 = 32'h44332211;
    localparam logic [31:0] EXP_DEADBEEF = 32'hEFBEADDE;
    localparam logic [31:0] EXP_CAFEF00D = 32'h0DF0FECA;
`else
    localparam logic [31:0] EXP_11223344 = 32'h11223344;
    localparam logic [31:0] EXP_DEADBEEF = 32'hDEADBEEF;
    localparam logic [31:0] EXP_CAFEF00D = 32'hCAFEF00D;
`endif

    // instance A (default parameters)
    logic        req_valid_a = 1'b0, req_ready_a, resp_valid_a, resp_err_a, busy_a;
    logic [23:0] req_addr_a = '0;
    logic [31:0] resp_data_a, dat_o_a, dat_i_a;
    logic [4:0]  adr_a;
    logic [3:0]  sel_a;
    logic        we_a, cyc_a, stb_a, ack_a, err_a;

    // instance B (POLL_MAX = 4)
    logic        req_valid_b = 1'b0, req_ready_b, resp_valid_b, resp_err_b, busy_b;
    logic [23:0] req_addr_b = '0;
    logic [31:0] resp_data_b, dat_o_b, dat_i_b;
    logic [4:0]  adr_b;
    logic [3:0]  sel_b;
    logic        we_b, cyc_b, stb_b, ack_b, err_b;

    spi_xip_seq dut_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
        .resp_valid(resp_valid_a), .resp_data(resp_data_a), .resp_err(resp_err_a), .busy(busy_a),
        .wb_adr_o(adr_a), .wb_dat_o(dat_o_a), .wb_sel_o(sel_a), .wb_we_o(we_a),
        .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_dat_i(dat_i_a), .wb_ack_i(ack_a), .wb_err_i(err_a)
    );

    spi_xip_seq #(.POLL_MAX(4)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
        .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_err(resp_err_b), .busy(busy_b),
        .wb_adr_o(adr_b), .wb_dat_o(dat_o_b), .wb_sel_o(sel_b), .wb_we_o(we_b),
        .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_dat_i(dat_i_b), .wb_ack_i(ack_b), .wb_err_i(err_b)
    );

    // slave A: zero-wait ack, optional error on one address, GO_BSY busy for busy_limit_a polls
    logic [31:0] rx0_a = 32'h0;
    logic        err_en_a = 1'b0;
    logic [4:0]  err_adr_a = 5'h00;
    int          ctrl_reads_a = 0, ctrl_base_a = 0, busy_limit_a = 0;
    logic [41:0] log_a [0:63];
    int          log_n_a = 0;

    assign err_a   = cyc_a && stb_a && err_en_a && (adr_a == err_adr_a);
    assign ack_a   = cyc_a && stb_a && !err_a;
    assign dat_i_a = (adr_a == 5'h10) ? (((ctrl_reads_a - ctrl_base_a) < busy_limit_a) ? 32'h100 : 32'h0)
                                      : rx0_a;

    always @(posedge clock) begin
        if (cyc_a && (ack_a || err_a)) begin
            if (log_n_a < 64) log_a[log_n_a] <= {sel_a, we_a, adr_a, dat_o_a};
            log_n_a <= log_n_a + 1;
            if (ack_a && !we_a && adr_a == 5'h10) ctrl_reads_a <= ctrl_reads_a + 1;
        end
    end

    // slave B: GO_BSY never clears
    int ctrl_reads_b = 0, ss_clr_b = 0;
    assign ack_b   = cyc_b && stb_b;
    assign err_b   = 1'b0;
    assign dat_i_b = (adr_b == 5'h10) ? 32'h100 : 32'h0;

    always @(posedge clock) begin
        if (cyc_b && ack_b) begin
            if (!we_b && adr_b == 5'h10) ctrl_reads_b <= ctrl_reads_b + 1;
            if (we_b && adr_b == 5'h18 && dat_o_b == 32'h0) ss_clr_b <= ss_clr_b + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic req_a(input logic [23:0] a);
        @(negedge clock);
        req_valid_a = 1'b1;
        req_addr_a  = a;
        @(posedge clock);
        #1;
        req_valid_a = 1'b0;
    endtask

    // lat = index of the cycle (accept cycle = 0) in which resp_valid is seen
    task automatic wait_resp_a(output int lat);
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clock);
            if (resp_valid_a) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("resp_a_timeout", {63'd0, resp_valid_a}, 64'd1);
    endtask

    logic [41:0] exp1 [0:6];
    logic [41:0] exp5 [0:2];
    int lat, base, cbase, seen, found;

    initial begin
        exp1[0] = {4'hF, 1'b1, 5'h04, 32'h03123456};
        exp1[1] = {4'hF, 1'b1, 5'h14, 32'h00000001};
        exp1[2] = {4'hF, 1'b1, 5'h18, 32'h00000001};
        exp1[3] = {4'hF, 1'b1, 5'h10, 32'h00000140};
        exp1[4] = {4'h0, 1'b0, 5'h10, 32'h00000000};
        exp1[5] = {4'hF, 1'b1, 5'h18, 32'h00000000};
        exp1[6] = {4'h0, 1'b0, 5'h00, 32'h00000000};
        exp5[0] = {4'hF, 1'b1, 5'h04, 32'h03654321};
        exp5[1] = {4'hF, 1'b1, 5'h14, 32'h00000001};
        exp5[2] = {4'hF, 1'b1, 5'h18, 32'h00000000};

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_req_ready", {63'd0, req_ready_a}, 64'd1);
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid_a}, 64'd0);
        check("rst_resp_err", {63'd0, resp_err_a}, 64'd0);
        check("rst_resp_data", {32'd0, resp_data_a}, 64'd0);
        check("rst_cyc_stb", {62'd0, cyc_a, stb_a}, 64'd0);
        check("rst_wb_out", {22'd0, sel_a, we_a, adr_a, dat_o_a}, 64'd0);

        // 1: nominal read, GO_BSY clear on first poll
        rx0_a = 32'h11223344;
        busy_limit_a = 0;
        ctrl_base_a = ctrl_reads_a;
        base = log_n_a;
        req_a(24'h123456);
        check("t1_busy", {63'd0, busy_a}, 64'd1);
        check("t1_req_ready", {63'd0, req_ready_a}, 64'd0);
        wait_resp_a(lat);
        check("t1_latency", 64'(lat), 64'd15);
        check("t1_data", {32'd0, resp_data_a}, {32'd0, EXP_11223344});
        check("t1_err", {63'd0, resp_err_a}, 64'd0);
        check("t1_ready_in_resp", {63'd0, req_ready_a}, 64'd0);
        check("t1_access_count", 64'(log_n_a - base), 64'd7);
        for (int i = 0; i < 7; i++) check($sformatf("t1_access%0d", i), {22'd0, log_a[base + i]}, {22'd0, exp1[i]});
        @(negedge clock);
        check("t1_pulse_width", {63'd0, resp_valid_a}, 64'd0);
        check("t1_ready_after", {63'd0, req_ready_a}, 64'd1);
        check("t1_data_held", {32'd0, resp_data_a}, {32'd0, EXP_11223344});

        // 2: data formatting
        rx0_a = 32'hDEADBEEF;
        req_a(24'h000010);
        wait_resp_a(lat);
        check("t2_latency", 64'(lat), 64'd15);
        check("t2_data", {32'd0, resp_data_a}, {32'd0, EXP_DEADBEEF});
        check("t2_err", {63'd0, resp_err_a}, 64'd0);

        // 3: GO_BSY set for 5 polls
        busy_limit_a = 5;
        ctrl_base_a = ctrl_reads_a;
        cbase = ctrl_reads_a;
        req_a(24'h000020);
        wait_resp_a(lat);
        check("t3_ctrl_reads", 64'(ctrl_reads_a - cbase), 64'd6);
        check("t3_latency", 64'(lat), 64'd25);
        check("t3_err", {63'd0, resp_err_a}, 64'd0);
        check("t3_data", {32'd0, resp_data_a}, {32'd0, EXP_DEADBEEF});
        busy_limit_a = 0;

        // 4: poll timeout on the POLL_MAX=4 instance
        @(negedge clock);
        req_valid_b = 1'b1;
        req_addr_b  = 24'h000040;
        @(posedge clock);
        #1;
        req_valid_b = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (resp_valid_b) begin
                found = 1;
                break;
            end
        end
        check("t4_resp_seen", 64'(found), 64'd1);
        check("t4_ctrl_reads", 64'(ctrl_reads_b), 64'd4);
        check("t4_ss_cleared", 64'(ss_clr_b), 64'd1);
        check("t4_err", {63'd0, resp_err_b}, 64'd1);
        check("t4_data", {32'd0, resp_data_b}, 64'd0);

        // 5: bus error on the DIVIDER write, then a clean request
        err_en_a = 1'b1;
        err_adr_a = 5'h14;
        base = log_n_a;
        req_a(24'h654321);
        wait_resp_a(lat);
        check("t5_err", {63'd0, resp_err_a}, 64'd1);
        check("t5_data", {32'd0, resp_data_a}, 64'd0);
        check("t5_access_count", 64'(log_n_a - base), 64'd3);
        for (int i = 0; i < 3; i++) check($sformatf("t5_access%0d", i), {22'd0, log_a[base + i]}, {22'd0, exp5[i]});
        err_en_a = 1'b0;
        rx0_a = 32'hCAFEF00D;
        ctrl_base_a = ctrl_reads_a;
        req_a(24'h000080);
        wait_resp_a(lat);
        check("t5_next_latency", 64'(lat), 64'd15);
        check("t5_next_err", {63'd0, resp_err_a}, 64'd0);
        check("t5_next_data", {32'd0, resp_data_a}, {32'd0, EXP_CAFEF00D});

        // 6: reset while polling, then req_valid held across RESP
        busy_limit_a = 1000;
        ctrl_base_a = ctrl_reads_a;
        req_a(24'h000100);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (cyc_a && !we_a && adr_a == 5'h10) begin
                found = 1;
                break;
            end
        end
        check("t6_in_poll", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_cyc_stb", {62'd0, cyc_a, stb_a}, 64'd0);
        check("t6_rst_resp_valid", {63'd0, resp_valid_a}, 64'd0);
        check("t6_rst_req_ready", {63'd0, req_ready_a}, 64'd1);
        check("t6_rst_busy", {63'd0, busy_a}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (resp_valid_a) seen++;
        end
        check("t6_no_resp_after_reset", 64'(seen), 64'd0);
        busy_limit_a = 0;
        ctrl_base_a = ctrl_reads_a;
        @(negedge clock);
        req_valid_a = 1'b1;
        req_addr_a  = 24'h000200;
        @(posedge clock);
        #1;
        check("t6_first_accept", {63'd0, busy_a}, 64'd1);
        wait_resp_a(lat);
        check("t6_latency", 64'(lat), 64'd15);
        check("t6_ready_in_resp", {63'd0, req_ready_a}, 64'd0);
        @(negedge clock);
        check("t6_ready_after_resp", {63'd0, req_ready_a}, 64'd1);
        @(posedge clock);
        #1;
        check("t6_second_accept", {63'd0, busy_a}, 64'd1);
        check("t6_second_tx1", {26'd0, cyc_a, adr_a, dat_o_a}, {26'd0, 1'b1, 5'h04, 32'h03000200});
        req_valid_a = 1'b0;
        wait_resp_a(lat);
        check("t6_second_latency", 64'(lat), 64'd15);
        check("t6_second_err", {63'd0, resp_err_a}, 64'd0);
        check("t6_second_data", {32'd0, resp_data_a}, {32'd0, EXP_CAFEF00D});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
